// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, controller state type and opcode helpers
// used by the ALU issue controller and its latency counter.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_SHL   = 5'b01010;
  localparam logic [4:0] OP_ROR   = 5'b01011;
  localparam logic [4:0] OP_ROL   = 5'b01100;
  localparam logic [4:0] OP_ADDI  = 5'b01101;
  localparam logic [4:0] OP_ANDI  = 5'b01110;
  localparam logic [4:0] OP_ORI   = 5'b01111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_DIV   = 5'b10001;
  localparam logic [4:0] OP_NEG   = 5'b10010;
  localparam logic [4:0] OP_NOT   = 5'b10011;
  localparam logic [4:0] OP_NOP   = 5'b11110;
  localparam logic [4:0] OP_INCPC = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_NOP, OP_INCPC: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter that sets the ALU hold time: loads a cycle count, decrements
// while enabled and flags the final cycle.
module alu_lat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time, holds its operands for a per-opcode
// latency, then returns the captured 64-bit result over valid/ready.
// Optional macro ALU_ISSUE_BACKTOBACK_EN lets a new request be accepted on
// the same edge as the response handoff.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic [4:0]  rsp_op,
  output logic        rsp_illegal,
  output logic        rsp_divz,
  output logic        busy
);

  localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT)) + 1;

  state_t state, state_next;

  logic        accept;
  logic        handoff;
  logic        req_legal;
  logic        req_divz;
  logic [CNT_W-1:0] load_val;
  logic        cnt_last;

  logic [4:0]  hold_op;
  logic [4:0]  hold_alu_op;
  logic [31:0] hold_a;
  logic [31:0] hold_b;
  logic        hold_illegal;
  logic        hold_divz;
  logic        issued;

  assign accept    = req_valid && req_ready;
  assign handoff   = rsp_valid && rsp_ready;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  assign req_legal = is_legal_op(req_op);
  assign req_divz  = (req_op == OP_DIV) && (req_b == 32'h0);

  always_comb begin
    load_val = CNT_W'(1);
    if (req_op == OP_MUL) begin
      load_val = CNT_W'(MUL_LAT);
    end else if (req_op == OP_DIV && !req_divz) begin
      load_val = CNT_W'(DIV_LAT);
    end
  end

  // NOTE: defaults first so every path assigns each output; no latches.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (issued && cnt_last) state_next = ST_RESP;
      end
      ST_RESP: begin
`ifdef ALU_ISSUE_BACKTOBACK_EN
        req_ready = rsp_ready;
`endif
        if (handoff) state_next = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The first EXEC cycle moves the held request onto the ALU; the counter
  // only runs once the operands are actually presented.
  alu_lat_counter #(.W(CNT_W)) u_lat (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (load_val),
    .dec      (state == ST_EXEC && issued),
    .last     (cnt_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      hold_op      <= 5'h0;
      hold_alu_op  <= OP_NOP;
      hold_a       <= 32'h0;
      hold_b       <= 32'h0;
      hold_illegal <= 1'b0;
      hold_divz    <= 1'b0;
      issued       <= 1'b0;
      alu_a        <= 32'h0;
      alu_b        <= 32'h0;
      alu_op       <= OP_NOP;
      rsp_hi       <= 32'h0;
      rsp_lo       <= 32'h0;
      rsp_op       <= 5'h0;
      rsp_illegal  <= 1'b0;
      rsp_divz     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        hold_op      <= req_op;
        hold_alu_op  <= (!req_legal || req_divz) ? OP_NOP : req_op;
        hold_a       <= req_a;
        hold_b       <= req_b;
        hold_illegal <= !req_legal;
        hold_divz    <= req_divz;
        issued       <= 1'b0;
      end else if (state == ST_EXEC && !issued) begin
        issued <= 1'b1;
        alu_a  <= hold_a;
        alu_b  <= hold_b;
        alu_op <= hold_alu_op;
      end else if (state == ST_EXEC && cnt_last) begin
        alu_a       <= 32'h0;
        alu_b       <= 32'h0;
        alu_op      <= OP_NOP;
        // Skipped operations report zero instead of whatever the idle ALU drives.
        {rsp_hi, rsp_lo} <= (hold_illegal || hold_divz) ? 64'h0 : alu_c;
        rsp_op      <= hold_op;
        rsp_illegal <= hold_illegal;
        rsp_divz    <= hold_divz;
      end
    end
  end

endmodule
